// File: rtl/unidade_controle_contagem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | unidade_controle_contagem: start/prepare/count/finish control FSM that   |
// | drives an external 4-bit counter and comparator. Rev 1.0                 |
// +--------------------------------------------------------------------------+
module unidade_controle_contagem #(
    parameter int TIMEOUT = 20
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       iniciar,
    input  logic [3:0] alvo,
    input  logic       A_igual_a_B,
    input  logic       A_maior_que_B,
    input  logic       RCO,
    output logic       zera_n,
    output logic       carrega_n,
    output logic       conta,
    output logic [3:0] dado_B,
    output logic       pronto,
    output logic       erro,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PREPARA = 3'd1,
        CONTA   = 3'd2,
        FIM     = 3'd3,
        ERRO    = 3'd4
    } estado_t;

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    estado_t    estado_q, estado_d;
    logic [3:0] dado_b_q, dado_b_d;
    logic [7:0] tmo_q,    tmo_d;
    logic       erro_q,   erro_d;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            estado_q <= OCIOSO;
            dado_b_q <= 4'd0;
            tmo_q    <= 8'd0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            dado_b_q <= dado_b_d;
            tmo_q    <= tmo_d;
            erro_q   <= erro_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        dado_b_d = dado_b_q;
        tmo_d    = tmo_q;
        erro_d   = erro_q;
        conta    = 1'b0;
        zera_n   = 1'b1;
        pronto   = 1'b0;
        case (estado_q)
            OCIOSO, ERRO: begin
                if (iniciar) begin
                    estado_d = PREPARA;
                    dado_b_d = alvo;
                    erro_d   = 1'b0;
                    tmo_d    = 8'd0;
                end
            end
            PREPARA: begin
                zera_n   = 1'b0;
                estado_d = CONTA;
            end
            CONTA: begin
                // Mealy enable: the counter halts on the very cycle it hits the target
                conta = ~A_igual_a_B;
                if (A_igual_a_B) begin
                    estado_d = FIM;
                end else if (A_maior_que_B || RCO || (tmo_q == C_TMO_LAST)) begin
                    estado_d = ERRO;
                    erro_d   = 1'b1;
                end else if (tmo_q != 8'hFF) begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            FIM: begin
                pronto   = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign carrega_n = 1'b1;
    assign dado_B    = dado_b_q;
    assign erro      = erro_q;
    assign db_estado = estado_q;

endmodule
`default_nettype wire

// File: doc/unidade_controle_contagem.md
UNIDADE_CONTROLE_CONTAGEM -- requirements
Module: unidade_controle_contagem

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 20, meaning the maximum number of cycles spent in CONTA before an error is raised (legal range 2..255).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes occur on the rising edge.
REQ-003 The block SHALL have port CLR  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port iniciar  input  1  start request, sampled on the rising edge.
REQ-005 The block SHALL have port alvo  input  4  target count, captured at start.
REQ-006 The block SHALL have port A_igual_a_B  input  1  counter equals target (from the downstream counter/comparator).
REQ-007 The block SHALL have port A_maior_que_B  input  1  counter exceeds target.
REQ-008 The block SHALL have port RCO  input  1  counter ripple carry (count = 15 while enabled).
REQ-009 The block SHALL have port zera_n  output  1  active-low synchronous clear command to the counter.
REQ-010 The block SHALL have port carrega_n  output  1  active-low load command to the counter; it SHALL be held at 1 (never load).
REQ-011 The block SHALL have port conta  output  1  count enable (drives ENP).
REQ-012 The block SHALL have port dado_B  output  4  registered target, driving comparator inputs B_3..B_0.
REQ-013 The block SHALL have port pronto  output  1  one-cycle completion pulse.
REQ-014 The block SHALL have port erro  output  1  error flag, held until the next start.
REQ-015 The block SHALL have port db_estado  output  3  current state code, for debug.

Function
REQ-016 The state encoding SHALL be: OCIOSO=0, PREPARA=1, CONTA=2, FIM=3, ERRO=4; codes 5..7 SHALL go to OCIOSO on the next edge.
REQ-017 In OCIOSO with iniciar=1, the block SHALL capture alvo into dado_B, clear erro, clear the timeout counter and go to PREPARA; with iniciar=0 it SHALL stay in OCIOSO.
REQ-018 In PREPARA, zera_n SHALL be 0 for exactly that one cycle, and the next state SHALL be CONTA unconditionally.
REQ-019 In CONTA, the output SHALL be conta = NOT A_igual_a_B (Mealy), so the counter stops exactly on the target with no overshoot.
REQ-020 CONTA transition priority SHALL be: A_igual_a_B=1 -> FIM; else A_maior_que_B=1 or RCO=1 -> ERRO; else timeout counter = TIMEOUT-1 -> ERRO; else stay in CONTA and increment the timeout counter.
REQ-021 The timeout counter SHALL be 8-bit, count only in CONTA, and never wrap (saturating is acceptable but unreachable).
REQ-022 In FIM, pronto SHALL be 1 for exactly one cycle, followed by OCIOSO; iniciar is ignored in FIM.
REQ-023 In ERRO, erro SHALL be 1 and the block SHALL stay in ERRO until iniciar=1, which behaves as in OCIOSO (goes to PREPARA and clears erro on the same edge).
REQ-024 dado_B SHALL be held stable from capture until the next accepted start; changes on alvo outside a start SHALL be ignored.
REQ-025 When alvo=0, the first CONTA cycle SHALL see A_igual_a_B=1: conta=0, FIM follows, and zero increments are issued.
REQ-026 When alvo=15, A_igual_a_B SHALL take priority over a simultaneous RCO, giving FIM rather than ERRO.
REQ-027 Outside CONTA, conta SHALL be 0; outside PREPARA, zera_n SHALL be 1.
REQ-028 iniciar held high continuously SHALL cause back-to-back operations: OCIOSO -> PREPARA each time FIM returns to OCIOSO.

Reset
REQ-029 CLR=0 SHALL immediately, without waiting for a clock edge, force OCIOSO, dado_B=0000, timeout counter=0, pronto=0, erro=0, conta=0, zera_n=1, carrega_n=1 and db_estado=000.
REQ-030 Reset asserted mid-CONTA SHALL abort the operation with no pronto and no erro; after release, the block SHALL wait for a new iniciar.

Verification
REQ-031 A bench SHALL cover: reset, then iniciar pulse with alvo=0101 and the real counter attached -> zera_n low 1 cycle, conta high exactly 5 cycles, pronto pulse, counter at 5, A_igual_a_B=1.
REQ-032 A bench SHALL cover: alvo=0000 -> PREPARA, CONTA (conta=0), FIM; pronto 3 cycles after start; zero increments.
REQ-033 A bench SHALL cover: alvo=1111 -> 15 increments, pronto=1, erro=0 despite RCO.
REQ-034 A bench SHALL cover: A_igual_a_B forced 0 (counter stalled), TIMEOUT=20 -> ERRO after 20 CONTA cycles, erro=1 held; next iniciar clears erro.
REQ-035 A bench SHALL cover: A_maior_que_B forced 1 during CONTA -> ERRO next edge, conta=0.
REQ-036 A bench SHALL cover: CLR=0 pulsed between clock edges mid-count -> outputs at reset values before the next edge; no pronto afterward.
